// File: rtl/mix_columns_pipe.sv
// AES MixColumns / InvMixColumns / bypass engine with valid-ready handshake.
// Processes COLS_PER_CYCLE columns per clock and holds the result until it is accepted.
module mix_columns_pipe #(
  parameter  int COLS_PER_CYCLE = 1,
  localparam int N_GROUPS       = 4 / COLS_PER_CYCLE,
  localparam int TEXT_WIDTH     = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            mode_i,
  input  logic [TEXT_WIDTH-1:0] state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TEXT_WIDTH-1:0] state_o,
  output logic                  busy_o
);

  localparam int CNT_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_pipe: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        grp_q, grp_d;
  logic [1:0]              mode_q, mode_d;
  logic [TEXT_WIDTH-1:0]   in_q, in_d;
  logic [TEXT_WIDTH-1:0]   res_q, res_d;
  logic                    accept;
  int                      col;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward uses {2,3,1,1}, inverse {0e,0b,0d,09}; any other mode passes through.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [1:0] m);
    logic [7:0] s   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] r   [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (m == 2'b00) begin
        r[i] = x2[i] ^ (x2[(i+1)%4] ^ s[(i+1)%4]) ^ s[(i+2)%4] ^ s[(i+3)%4];
      end else if (m == 2'b01) begin
        r[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
             ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
      end else begin
        r[i] = s[i];
      end
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == BUSY);
  assign state_o     = res_q;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    mode_d  = mode_q;
    in_d    = in_q;
    res_d   = res_q;
    col     = 0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          in_d    = state_i;
          mode_d  = mode_i;
          grp_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          col = int'(grp_q) * COLS_PER_CYCLE + j;
          res_d[127-32*col -: 32] = mix_col(in_q[127-32*col -: 32], mode_q);
        end
        // Counter holds on the last group so it never wraps inside a block.
        if (grp_q == CNT_W'(N_GROUPS - 1)) begin
          state_d = DONE;
        end else begin
          grp_d = CNT_W'(grp_q + 1'b1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          if (accept) begin
            in_d    = state_i;
            mode_d  = mode_i;
            grp_d   = '0;
            state_d = BUSY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grp_q   <= '0;
      mode_q  <= '0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      mode_q  <= mode_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

endmodule
